sp_ram_bw: RTL and testbench
============================

# sp_ram_bw

Parametrised single-port RAM with per-byte write enables, a registered read port, a request/ready handshake and a hardware clear engine. A sequential walk zeroes every location after reset or on command, so the array needs no per-bit reset. It sits behind bus adapters as a general-purpose local store and is the drop-in successor for fixed 128x8 RAM instances.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8, minimum 8.
- DEPTH, 128, number of words; any value ≥ 2, not required to be a power of two.
- ADDR_W, $clog2(DEPTH), address width. This is a derived localparam and is not overridable.
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_i  in  1  access request; accepted when req_i && ready_o at a rising edge.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- addr_i  in  ADDR_W  word address.
- be_i  in  DATA_W/8  byte enables for writes; bit n covers wdata_i[8n+7:8n].
- wdata_i  in  DATA_W  write data.
- clr_i  in  1  single-cycle pulse; starts a full memory clear.
- ready_o  out  1  block accepts an access this cycle.
- init_busy_o  out  1  clear walk in progress.
- rvalid_o  out  1  rdata_o is valid this cycle; single-cycle pulse.
- rdata_o  out  DATA_W  read data; holds the last read value between reads.
- parity_err_o  out  1  parity mismatch on the current read; qualified by rvalid_o.

## Operation
- FSM has two states: INIT (clear walk) and ACTIVE (serving accesses).
- Reset state is INIT with the clear pointer at 0.
- Reset values:
  - ready_o = 0, init_busy_o = 1.
  - rvalid_o = 0, rdata_o = 0, parity_err_o = 0.
- INIT behaviour:
  - Each cycle, write all-zero to mem[ptr] and increment ptr.
  - On the cycle ptr = DEPTH-1 is written, move to ACTIVE.
  - ready_o = 0 and init_busy_o = 1 throughout INIT.
  - req_i and clr_i are ignored in INIT.
- ACTIVE behaviour:
  - ready_o = 1 and init_busy_o = 0.
  - A clr_i pulse moves the FSM to INIT with ptr = 0 on the next edge.
- Accepted write: for each n with be_i[n] = 1, update byte n of mem[addr_i]. Bytes with be_i[n] = 0 are untouched. be_i = 0 is a legal no-op.
- Accepted read: rdata_o <= mem[addr_i] and rvalid_o <= 1 on the same edge. rvalid_o returns to 0 the following cycle unless another read is accepted.
- Out-of-range address (addr_i ≥ DEPTH, possible only when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return 0 with rvalid_o = 1.
- clr_i and an accepted req_i in the same cycle:
  - The access completes first; a read returns pre-clear data.
  - INIT starts on the next edge.
- Reset asserted mid-INIT or mid-ACTIVE: immediate return to the reset values. The walk restarts from 0 after deassertion.

## Timing
- Clear walk: ready_o rises DEPTH rising edges after rst_n_i deasserts (or after the edge that samples clr_i).
- Read latency is 1 cycle: address accepted at edge k, data and rvalid_o are valid after edge k.
- Throughput is one access per cycle. Back-to-back reads and writes in any mix are allowed.
- Read-after-write to the same address on the next cycle returns the newly written bytes.
- ready_o depends only on FSM state, never combinationally on req_i.

## Configuration
- SPRAM_PARITY_EN defined:
  - Each byte stores one extra even-parity bit, so the array is DATA_W + DATA_W/8 bits wide.
  - Parity is written with the data on every write and by the clear walk (parity of 0x00 = 0).
  - Parity is recomputed on read. parity_err_o = 1 in the rvalid_o cycle if any byte mismatches.
  - Out-of-range reads report parity_err_o = 0.
- SPRAM_PARITY_EN undefined:
  - No parity storage.
  - parity_err_o is tied to 0; the port remains present.

## Test plan
- Reset release, DATA_W=32, DEPTH=128 -> ready_o = 0 for exactly 128 cycles, then 1. A read of every address returns 0x00000000.
- Write 0xDEADBEEF to addr 5 with be_i = 4'hF, then write 0x11223344 with be_i = 4'b0101, then read addr 5 -> rdata_o = 0xDE22BE44 one cycle after the read is accepted, rvalid_o high for 1 cycle.
- Alternate write/read of addr 9 every cycle with incrementing data -> each read returns the value from the immediately preceding write, with no bubbles.
- DEPTH=100: write 0xA5A5A5A5 to addr 120, then read addr 120 -> rdata_o = 0, rvalid_o = 1. Addr 99 contents are unchanged.
- Fill memory, pulse clr_i while issuing a read of addr 3 holding 0x12345678 -> rdata_o = 0x12345678 next cycle. ready_o then drops for DEPTH cycles, and all addresses read 0 afterwards.
- Assert rst_n_i at walk pointer 40, then release -> a full DEPTH-cycle walk restarts from 0. With SPRAM_PARITY_EN, parity_err_o stays 0 on all subsequent reads.

Source files
------------

// File: rtl/sp_ram_bw_if.sv
// Access bus for sp_ram_bw.
// Signal names are written from the RAM's point of view (_i into the RAM, _o out of it).
// Parameters:
//   DATA_W - word width in bits (a multiple of 8)
//   DEPTH  - number of words
// Signals:
//   req_i/we_i/addr_i/be_i/wdata_i - access request, write flag, word address, byte enables, write data
//   clr_i                          - single-cycle pulse that starts a full clear
//   ready_o/init_busy_o            - access accepted this cycle / clear walk running
//   rvalid_o/rdata_o/parity_err_o  - read response
// Modports:
//   master - bus adapter side
//   slave  - RAM side
interface sp_ram_bw_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [BE_W-1:0]   be_i;
    logic [DATA_W-1:0] wdata_i;
    logic              clr_i;
    logic              ready_o;
    logic              init_busy_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              parity_err_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i, clr_i,
        input  ready_o, init_busy_o, rvalid_o, rdata_o, parity_err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i, clr_i,
        output ready_o, init_busy_o, rvalid_o, rdata_o, parity_err_o
    );
endinterface

// File: rtl/sp_ram_bw.sv
// Single-port RAM with per-byte write enables, a registered read port and a
// hardware clear walk that zeroes every word after reset or on clr_i.
// The array has no per-bit reset; the walk provides the known contents.
// Optional feature macro: SPRAM_PARITY_EN adds one even-parity bit per byte
// and reports mismatches on parity_err_o; without it parity_err_o is 0.
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset
//   bus     - sp_ram_bw_if slave modport (request, write data, read response, status)
module sp_ram_bw #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    sp_ram_bw_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned NB     = DATA_W / 8;
`ifdef SPRAM_PARITY_EN
    localparam int unsigned MEM_W  = DATA_W + NB;
`else
    localparam int unsigned MEM_W  = DATA_W;
`endif

    typedef enum logic {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ready;
    logic              r_busy;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_perr;

    // Layout per word: data in [DATA_W-1:0], parity of byte n at bit DATA_W+n
    logic [MEM_W-1:0]  r_mem [DEPTH];

    logic              w_accept;
    logic              w_in_range;
    logic              w_wr;
    logic              w_rd;
    logic [MEM_W-1:0]  w_rword;
    logic              w_rd_perr;

    // Accept depends only on registered ready, never on req_i combinationally
    assign w_accept   = r_ready & bus.req_i;
    // Needed only when DEPTH is not a power of two
    assign w_in_range = 32'(bus.addr_i) < DEPTH;
    assign w_wr       = w_accept & bus.we_i & w_in_range;
    assign w_rd       = w_accept & ~bus.we_i;

    // Read word (zero for out-of-range addresses) and its parity check
    always_comb begin
        w_rword   = '0;
        w_rd_perr = 1'b0;
        if (w_in_range) begin
            w_rword = r_mem[bus.addr_i];
        end
`ifdef SPRAM_PARITY_EN
        for (int n = 0; n < int'(NB); n++) begin
            w_rd_perr = w_rd_perr | ((^w_rword[8*n +: 8]) ^ w_rword[DATA_W + n]);
        end
`endif
    end

    // Storage: clear walk in INIT, byte-masked writes in ACTIVE
    always_ff @(posedge clk_i) begin
        if (r_state == ST_INIT) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr) begin
            for (int n = 0; n < int'(NB); n++) begin
                if (bus.be_i[n]) begin
                    r_mem[bus.addr_i][8*n +: 8] <= bus.wdata_i[8*n +: 8];
`ifdef SPRAM_PARITY_EN
                    r_mem[bus.addr_i][DATA_W + n] <= ^bus.wdata_i[8*n +: 8];
`endif
                end
            end
        end
    end

    // Control FSM with registered status and read response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_INIT;
            r_ptr    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_perr   <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_ACTIVE;
                        r_ptr   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // An access in the clr_i cycle still completes with pre-clear data
                    if (w_rd) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_rword[DATA_W-1:0];
                        r_perr   <= w_rd_perr;
                    end
                    if (bus.clr_i) begin
                        r_state <= ST_INIT;
                        r_ptr   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ptr   <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o      = r_ready;
    assign bus.init_busy_o  = r_busy;
    assign bus.rvalid_o     = r_rvalid;
    assign bus.rdata_o      = r_rdata;
    assign bus.parity_err_o = r_perr;
endmodule

// File: tb/tb_sp_ram_bw.sv
// Directed testbench for sp_ram_bw: a 32x128 instance (dut_a) and a 32x100
// instance (dut_b) for out-of-range addressing. Inputs change and outputs are
// sampled 1 time unit after the rising edge.
module tb_sp_ram_bw;
    localparam int unsigned DW = 32;
    localparam int unsigned DA = 128;
    localparam int unsigned DB = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_ram_bw_if #(.DATA_W(DW), .DEPTH(DA)) bus_a ();
    sp_ram_bw_if #(.DATA_W(DW), .DEPTH(DB)) bus_b ();

    sp_ram_bw #(.DATA_W(DW), .DEPTH(DA)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_a));
    sp_ram_bw #(.DATA_W(DW), .DEPTH(DB)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        bus_a.req_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = '0;
        bus_a.be_i  = '0;   bus_a.wdata_i = '0; bus_a.clr_i = 1'b0;
        bus_b.req_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = '0;
        bus_b.be_i  = '0;   bus_b.wdata_i = '0; bus_b.clr_i = 1'b0;
    endtask

    // Present one access to dut_a and advance one edge (req_i stays high)
    task automatic acc_a(input logic we, input int addr, input logic [3:0] be, input logic [31:0] d);
        bus_a.req_i = 1'b1; bus_a.we_i = we; bus_a.addr_i = 7'(addr);
        bus_a.be_i = be; bus_a.wdata_i = d;
        tick();
    endtask

    task automatic acc_b(input logic we, input int addr, input logic [3:0] be, input logic [31:0] d);
        bus_b.req_i = 1'b1; bus_b.we_i = we; bus_b.addr_i = 7'(addr);
        bus_b.be_i = be; bus_b.wdata_i = d;
        tick();
    endtask

    task automatic test_reset;
        int cnt_a;
        int cnt_b;
        idle_all();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bus_a.ready_o, bus_a.init_busy_o, bus_a.rvalid_o, bus_a.parity_err_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_status: got rdy/busy/rv/perr=%b expected 0100",
                     {bus_a.ready_o, bus_a.init_busy_o, bus_a.rvalid_o, bus_a.parity_err_o});
        end
        n_checks++;
        if (bus_a.rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 00000000", bus_a.rdata_o);
        end
        tick();
        rst_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (bus_b.ready_o === 1'b1 && cnt_b == 0) cnt_b = k;
            if (bus_a.ready_o === 1'b1) begin
                cnt_a = k;
                break;
            end
        end
        n_checks++;
        if (cnt_a != 128) begin
            n_fail++;
            $display("FAIL walk_len_a: ready after %0d edges expected 128", cnt_a);
        end
        n_checks++;
        if (cnt_b != 100) begin
            n_fail++;
            $display("FAIL walk_len_b: ready after %0d edges expected 100", cnt_b);
        end
        n_checks++;
        if (bus_a.init_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_walk: got %b expected 0", bus_a.init_busy_o);
        end
    endtask

    task automatic test_zero_readback;
        for (int a = 0; a < int'(DA); a++) begin
            acc_a(1'b0, a, 4'h0, 32'h0);
            n_checks++;
            if ({bus_a.rvalid_o, bus_a.parity_err_o, bus_a.rdata_o} !== {2'b10, 32'h0}) begin
                n_fail++;
                $display("FAIL zero_read[%0d]: got rv=%b perr=%b data=%h expected rv=1 perr=0 data=00000000",
                         a, bus_a.rvalid_o, bus_a.parity_err_o, bus_a.rdata_o);
            end
        end
        idle_all();
        tick();
        n_checks++;
        if (bus_a.rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_read_rvalid_drop: got %b expected 0", bus_a.rvalid_o);
        end
    endtask

    task automatic test_byte_enable;
        acc_a(1'b1, 5, 4'hF, 32'hDEADBEEF);
        n_checks++;
        if (bus_a.rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL be_write_rvalid: got %b expected 0", bus_a.rvalid_o);
        end
        acc_a(1'b1, 5, 4'b0101, 32'h11223344);
        acc_a(1'b0, 5, 4'h0, 32'h0);
        n_checks++;
        if ({bus_a.rvalid_o, bus_a.rdata_o} !== {1'b1, 32'hDE22BE44}) begin
            n_fail++;
            $display("FAIL be_merge: got rv=%b data=%h expected rv=1 data=de22be44",
                     bus_a.rvalid_o, bus_a.rdata_o);
        end
        idle_all();
        tick();
        n_checks++;
        if ({bus_a.rvalid_o, bus_a.rdata_o} !== {1'b0, 32'hDE22BE44}) begin
            n_fail++;
            $display("FAIL be_hold: got rv=%b data=%h expected rv=0 data=de22be44",
                     bus_a.rvalid_o, bus_a.rdata_o);
        end
        // be_i = 0 must leave the word untouched
        acc_a(1'b1, 5, 4'h0, 32'hFFFFFFFF);
        acc_a(1'b0, 5, 4'h0, 32'h0);
        n_checks++;
        if (bus_a.rdata_o !== 32'hDE22BE44) begin
            n_fail++;
            $display("FAIL be_zero_noop: got %h expected de22be44", bus_a.rdata_o);
        end
        idle_all();
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            exp_d = 32'h1000_0000 + 32'(i * 3);
            acc_a(1'b1, 9, 4'hF, exp_d);
            n_checks++;
            if (bus_a.rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_wr_rvalid[%0d]: got %b expected 0", i, bus_a.rvalid_o);
            end
            acc_a(1'b0, 9, 4'h0, 32'h0);
            n_checks++;
            if ({bus_a.rvalid_o, bus_a.rdata_o} !== {1'b1, exp_d}) begin
                n_fail++;
                $display("FAIL b2b_rd[%0d]: got rv=%b data=%h expected rv=1 data=%h",
                         i, bus_a.rvalid_o, bus_a.rdata_o, exp_d);
            end
        end
        idle_all();
        tick();
    endtask

    task automatic test_out_of_range;
        acc_b(1'b1, 99, 4'hF, 32'h5A5A0001);
        acc_b(1'b1, 120, 4'hF, 32'hA5A5A5A5);
        acc_b(1'b0, 120, 4'h0, 32'h0);
        n_checks++;
        if ({bus_b.rvalid_o, bus_b.parity_err_o, bus_b.rdata_o} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL oor_read: got rv=%b perr=%b data=%h expected rv=1 perr=0 data=00000000",
                     bus_b.rvalid_o, bus_b.parity_err_o, bus_b.rdata_o);
        end
        acc_b(1'b0, 99, 4'h0, 32'h0);
        n_checks++;
        if ({bus_b.rvalid_o, bus_b.rdata_o} !== {1'b1, 32'h5A5A0001}) begin
            n_fail++;
            $display("FAIL oor_addr99: got rv=%b data=%h expected rv=1 data=5a5a0001",
                     bus_b.rvalid_o, bus_b.rdata_o);
        end
        idle_all();
        tick();
    endtask

    task automatic test_clear_collision;
        int cnt;
        int rv_seen;
        for (int a = 0; a < int'(DA); a++) begin
            acc_a(1'b1, a, 4'hF, (a == 3) ? 32'h12345678 : (32'hC0DE0000 | 32'(a)));
        end
        acc_a(1'b0, 100, 4'h0, 32'h0);
        n_checks++;
        if (bus_a.rdata_o !== 32'hC0DE0064) begin
            n_fail++;
            $display("FAIL fill_check: got %h expected c0de0064", bus_a.rdata_o);
        end
        // Read and clear in the same cycle
        bus_a.clr_i = 1'b1;
        acc_a(1'b0, 3, 4'h0, 32'h0);
        bus_a.clr_i = 1'b0;
        n_checks++;
        if ({bus_a.rvalid_o, bus_a.rdata_o, bus_a.ready_o, bus_a.init_busy_o} !== {1'b1, 32'h12345678, 2'b01}) begin
            n_fail++;
            $display("FAIL clr_collide: got rv=%b data=%h rdy=%b busy=%b expected rv=1 data=12345678 rdy=0 busy=1",
                     bus_a.rvalid_o, bus_a.rdata_o, bus_a.ready_o, bus_a.init_busy_o);
        end
        // Requests during the walk must be ignored (addr 0 is cleared first)
        bus_a.req_i = 1'b1; bus_a.we_i = 1'b1; bus_a.addr_i = '0;
        bus_a.be_i = 4'hF; bus_a.wdata_i = 32'hFFFFFFFF;
        cnt = 0;
        rv_seen = 0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (bus_a.rvalid_o === 1'b1) rv_seen++;
            if (bus_a.ready_o === 1'b1) begin
                cnt = k;
                break;
            end
        end
        idle_all();
        n_checks++;
        if (cnt != 128) begin
            n_fail++;
            $display("FAIL clr_walk_len: ready after %0d edges expected 128", cnt);
        end
        n_checks++;
        if (rv_seen != 0) begin
            n_fail++;
            $display("FAIL clr_walk_rvalid: %0d rvalid pulses during walk expected 0", rv_seen);
        end
        for (int a = 0; a < int'(DA); a++) begin
            acc_a(1'b0, a, 4'h0, 32'h0);
            n_checks++;
            if ({bus_a.rvalid_o, bus_a.parity_err_o, bus_a.rdata_o} !== {2'b10, 32'h0}) begin
                n_fail++;
                $display("FAIL clr_zero[%0d]: got rv=%b perr=%b data=%h expected rv=1 perr=0 data=00000000",
                         a, bus_a.rvalid_o, bus_a.parity_err_o, bus_a.rdata_o);
            end
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid_walk;
        int cnt;
        acc_a(1'b1, 100, 4'hF, 32'hCAFEF00D);
        acc_a(1'b0, 100, 4'h0, 32'h0);
        idle_all();
        bus_a.clr_i = 1'b1;
        tick();
        bus_a.clr_i = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.ready_o, bus_a.init_busy_o, bus_a.rvalid_o, bus_a.rdata_o} !== {3'b010, 32'h0}) begin
            n_fail++;
            $display("FAIL midwalk_reset: got rdy=%b busy=%b rv=%b data=%h expected rdy=0 busy=1 rv=0 data=00000000",
                     bus_a.ready_o, bus_a.init_busy_o, bus_a.rvalid_o, bus_a.rdata_o);
        end
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (bus_a.ready_o === 1'b1) begin
                cnt = k;
                break;
            end
        end
        n_checks++;
        if (cnt != 128) begin
            n_fail++;
            $display("FAIL midwalk_restart_len: ready after %0d edges expected 128", cnt);
        end
        for (int a = 96; a < 104; a++) begin
            acc_a(1'b0, a, 4'h0, 32'h0);
            n_checks++;
            if ({bus_a.rvalid_o, bus_a.parity_err_o, bus_a.rdata_o} !== {2'b10, 32'h0}) begin
                n_fail++;
                $display("FAIL midwalk_zero[%0d]: got rv=%b perr=%b data=%h expected rv=1 perr=0 data=00000000",
                         a, bus_a.rvalid_o, bus_a.parity_err_o, bus_a.rdata_o);
            end
        end
        idle_all();
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_readback();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_clear_collision();
        test_reset_mid_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
